// File: rtl/uart_pkg.sv
// Shared UART register map, CON bit positions and FSM encodings.
// No latency or backpressure: constants and types only.
package uart_pkg;
    localparam logic [1:0] REG_TXD = 2'd0;
    localparam logic [1:0] REG_RXD = 2'd1;
    localparam logic [1:0] REG_CON = 2'd2;

    localparam int CON_TX_BUSY  = 0;
    localparam int CON_RX_VALID = 1;
    localparam int CON_RX_OVR   = 2;
    localparam int CON_TX_DONE  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;
endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter; tick is high for one cycle when it hits 0 while enabled.
// Latency: first tick load_val+1 cycles after load, then every DIV cycles; no backpressure.
module uart_baud_cnt #(
    parameter int DIV = 16,
    parameter int CW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tick
);
    logic [CW-1:0] cnt;

    assign tick = en && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= (cnt == '0) ? CW'(DIV - 1) : cnt - CW'(1);
        end
    end
endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON registers on the CPU data bus, combinational reads.
// Latency: TX starts the cycle after the store; stores while busy are dropped, no stall.
module mmio_uart
    import uart_pkg::*;
#(
    parameter int          BAUD_DIV  = 5208,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Hit,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int            CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);

    // Addresses below the base wrap to a huge offset and fail the range test.
    logic [29:0] word_off;
    logic [1:0]  reg_sel;
    assign word_off = Addr[31:2] - BASE_ADDR[31:2];
    assign Hit      = (word_off < 30'd3);
    assign reg_sel  = word_off[1:0];

    logic unused_bits;
    assign unused_bits = ^{WrData[31:8], Addr[1:0]};

    logic wr_txd, rd_rxd, rd_con;
    assign wr_txd = Hit && MemWr && (reg_sel == REG_TXD);
    assign rd_rxd = Hit && MemRd && (reg_sel == REG_RXD);
    assign rd_con = Hit && MemRd && (reg_sel == REG_CON);

    uart_state_t tx_state, rx_state;
    logic [7:0]  tx_sh, rx_sh, rx_data;
    logic [2:0]  tx_idx, rx_idx;
    logic        tx_tick, rx_tick;
    logic        tx_done, rx_valid, rx_overrun;
    logic        tx_busy, tx_fin, rx_ok;
    logic        rx_m, rx_s, rx_q, rx_fall;

    assign tx_busy = (tx_state != ST_IDLE);
    assign tx_fin  = (tx_state == ST_STOP) && tx_tick;
    assign rx_fall = rx_q && !rx_s;
    assign rx_ok   = (rx_state == ST_STOP) && rx_tick && rx_s;

    uart_baud_cnt #(.DIV(BAUD_DIV), .CW(CW)) u_tx_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (tx_busy),
        .load     (wr_txd && !tx_busy),
        .load_val (FULL_LD),
        .tick     (tx_tick)
    );

    // RX first load is half a bit so every later tick lands mid-bit.
    uart_baud_cnt #(.DIV(BAUD_DIV), .CW(CW)) u_rx_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (rx_state != ST_IDLE),
        .load     ((rx_state == ST_IDLE) && rx_fall),
        .load_val (HALF_LD),
        .tick     (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_sh    <= '0;
            tx_idx   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: if (wr_txd) begin
                    tx_sh    <= WrData[7:0];
                    tx_idx   <= '0;
                    uart_tx  <= 1'b0;
                    tx_state <= ST_START;
                end
                ST_START: if (tx_tick) begin
                    uart_tx  <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_state <= ST_DATA;
                end
                ST_DATA: if (tx_tick) begin
                    if (tx_idx == 3'd7) begin
                        uart_tx  <= 1'b1;
                        tx_state <= ST_STOP;
                    end else begin
                        uart_tx <= tx_sh[0];
                        tx_sh   <= tx_sh >> 1;
                        tx_idx  <= tx_idx + 3'd1;
                    end
                end
                ST_STOP: if (tx_tick) tx_state <= ST_IDLE;
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            rx_q     <= 1'b1;
            rx_state <= ST_IDLE;
            rx_sh    <= '0;
            rx_idx   <= '0;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
            case (rx_state)
                ST_IDLE: if (rx_fall) rx_state <= ST_START;
                ST_START: if (rx_tick) begin
                    rx_idx   <= '0;
                    rx_state <= rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (rx_tick) begin
                    rx_sh <= {rx_s, rx_sh[7:1]};
                    if (rx_idx == 3'd7) rx_state <= ST_STOP;
                    else                rx_idx   <= rx_idx + 3'd1;
                end
                ST_STOP: if (rx_tick) rx_state <= ST_IDLE;
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    // Flag sets take priority over read-to-clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            if (rx_ok) rx_data <= rx_sh;
            if (rx_ok)       rx_valid <= 1'b1;
            else if (rd_rxd) rx_valid <= 1'b0;
            if (rx_ok && rx_valid && !rd_rxd) rx_overrun <= 1'b1;
            else if (rd_con)                  rx_overrun <= 1'b0;
            if (tx_fin)      tx_done <= 1'b1;
            else if (rd_con) tx_done <= 1'b0;
        end
    end

    always_comb begin
        RdData = '0;
        if (Hit && MemRd) begin
            case (reg_sel)
                REG_RXD: RdData = {24'b0, rx_data};
                REG_CON: begin
                    RdData[CON_TX_BUSY]  = tx_busy;
                    RdData[CON_RX_VALID] = rx_valid;
                    RdData[CON_RX_OVR]   = rx_overrun;
                    RdData[CON_TX_DONE]  = tx_done;
                end
                default: RdData = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart.sv
// Directed bench for mmio_uart at BAUD_DIV = 16; inputs change 1 ns after posedge.
module tb_mmio_uart;
    localparam int          B    = 16;
    localparam logic [31:0] TXD  = 32'h4000_0018;
    localparam logic [31:0] RXD  = 32'h4000_001C;
    localparam logic [31:0] CON  = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRd, MemWr;
    logic [31:0] Addr, WrData, RdData;
    logic        Hit, uart_rx, uart_tx;
    logic        rx_drv, loop_en;
    logic [31:0] d;
    int          total = 0;
    int          bad   = 0;

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    mmio_uart #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .MemRd   (MemRd),
        .MemWr   (MemWr),
        .Addr    (Addr),
        .WrData  (WrData),
        .RdData  (RdData),
        .Hit     (Hit),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        MemWr = 1'b1; Addr = a; WrData = v;
        tick();
        MemWr = 1'b0; Addr = '0; WrData = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        MemRd = 1'b1; Addr = a;
        #1 v = RdData;
        tick();
        MemRd = 1'b0; Addr = '0;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = fr[i];
            repeat (B) tick();
        end
        rx_drv = 1'b1;
    endtask

    // Expected line level k cycles after a TXD store is accepted (k = 1 is the first start cycle).
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int idx;
        if (k > 10 * B) return 1'b1;
        idx = (k - 1) / B;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx - 1];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; MemRd = 1'b0; MemWr = 1'b0; Addr = '0; WrData = '0;
        rx_drv = 1'b1; loop_en = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (100) tick();

        // Reset state and decode
        chk("idle_tx", 32'(uart_tx), 32'd1);
        rd(CON, d); chk("rst_con", d, 32'h0);
        rd(RXD, d); chk("rst_rxd", d, 32'h0);
        MemRd = 1'b1; Addr = 32'h1000;
        #1 chk("miss_rd", RdData, 32'h0);
        chk("miss_hit", 32'(Hit), 32'd0);
        Addr = CON + 32'd3;
        #1 chk("con_hit", 32'(Hit), 32'd1);
        tick();
        MemRd = 1'b0; Addr = '0;

        // TX frame of 0xA5; CON reads at the completion cycle and after
        wr(TXD, 32'h1A5);
        for (int k = 1; k <= 162; k++) begin
            chk("tx_a5", 32'(uart_tx), 32'(exp_bit(8'hA5, k)));
            if (k == 161) begin
                Addr = CON;
                #1 chk("rd_low", RdData, 32'h0);
            end
            if (k == 160)      begin rd(CON, d); chk("con_busy_end", d, 32'h1); end
            else if (k == 161) begin rd(CON, d); chk("con_done", d, 32'h8); end
            else if (k == 162) begin rd(CON, d); chk("con_clr", d, 32'h0); end
            else tick();
        end

        // Store while busy is dropped
        wr(TXD, 32'h55);
        for (int k = 1; k <= 175; k++) begin
            chk("tx_55", 32'(uart_tx), 32'(exp_bit(8'h55, k)));
            if (k == 19) wr(TXD, 32'h33);
            else         tick();
        end
        rd(CON, d); chk("con_55", d, 32'h8);

        // RX single byte
        send(8'hC3, 1'b1);
        repeat (4) tick();
        rd(CON, d); chk("rx_c3_con", d, 32'h2);
        rd(RXD, d); chk("rx_c3", d, 32'hC3);
        rd(CON, d); chk("rx_c3_clr", d, 32'h0);

        // Overrun
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        repeat (4) tick();
        rd(CON, d); chk("ovr_con", d, 32'h6);
        rd(CON, d); chk("ovr_clr", d, 32'h2);
        rd(RXD, d); chk("ovr_rxd", d, 32'h22);
        rd(CON, d); chk("ovr_idle", d, 32'h0);

        // Short glitch is rejected
        rx_drv = 1'b0;
        repeat (3) tick();
        rx_drv = 1'b1;
        repeat (40) tick();
        rd(CON, d); chk("glitch_con", d, 32'h0);
        rd(RXD, d); chk("glitch_rxd", d, 32'h22);

        // Framing error discards the byte
        send(8'h5A, 1'b0);
        repeat (4) tick();
        rd(CON, d); chk("frm_con", d, 32'h0);
        rd(RXD, d); chk("frm_rxd", d, 32'h22);

        // Loopback
        loop_en = 1'b1;
        wr(TXD, 32'h7E);
        repeat (180) tick();
        rd(RXD, d); chk("loop_rxd", d, 32'h7E);
        rd(CON, d); chk("loop_con", d, 32'h8);
        loop_en = 1'b0;

        // Read and write in the same cycle, then reset mid-frame
        MemRd = 1'b1; MemWr = 1'b1; Addr = TXD; WrData = 32'h0F;
        #1 chk("rw_rd", RdData, 32'h0);
        tick();
        MemRd = 1'b0; MemWr = 1'b0; Addr = '0; WrData = '0;
        chk("rw_start", 32'(uart_tx), 32'd0);
        repeat (40) tick();
        rd(CON, d); chk("mid_busy", d, 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_tx", 32'(uart_tx), 32'd1);
        rst = 1'b0;
        rd(CON, d); chk("rst_mid_con", d, 32'h0);
        repeat (20) tick();
        chk("rst_idle_tx", 32'(uart_tx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
